// File: rtl/tree_pkg.sv
// Shared definitions for the tree-bitmap SRAM image: row layout, limits and
// the encoder state encoding. The lookup datapath decodes rows with the same
// field constants.
package tree_pkg;

  localparam int ROW_W  = 32;
  localparam int ADDR_W = 10;
  localparam int TREE_W = 16;

  localparam int SUM_MSB  = 31;
  localparam int SUM_LSB  = 24;
  localparam int LVL_MSB  = 23;
  localparam int LVL_LSB  = 16;
  localparam int TREE_MSB = 15;
  localparam int TREE_LSB = 0;

  localparam int LVL_ONES_MAX = 255;
  localparam int ADDR_MAX     = (1 << ADDR_W) - 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_DRAIN,
    ST_DONE
  } enc_state_e;

  // Assemble one SRAM row {sum, lvl_ones, tree_val}.
  function automatic logic [ROW_W-1:0] pack_row(input logic [7:0]        sum,
                                                input logic [7:0]        lvl_ones,
                                                input logic [TREE_W-1:0] tree_val);
    logic [ROW_W-1:0] row;
    row = '0;
    row[SUM_MSB:SUM_LSB]   = sum;
    row[LVL_MSB:LVL_LSB]   = lvl_ones;
    row[TREE_MSB:TREE_LSB] = tree_val;
    return row;
  endfunction

endpackage

// File: rtl/popcount16.sv
// Population count of a 16-bit node bitmap (0..16).
module popcount16 (
  input  logic [15:0] bits,
  output logic [4:0]  ones
);

  // Plain adder chain; synthesis folds it into a compressor tree.
  always_comb begin
    ones = '0;
    for (int i = 0; i < 16; i++) begin
      ones = ones + 5'(bits[i]);
    end
  end

endmodule

// File: rtl/tree_sram_encoder.sv
// Buffers one trie level of node bitmaps, then writes packed rows
// {prefix ones, level ones, bitmap} contiguously into SRAM.
//
// state | meaning
// IDLE  | waiting for start
// FILL  | accepting bitmaps of the current level into the buffer
// DRAIN | writing one buffered row per cycle
// DONE  | one-cycle end-of-tree pulse (suppressed after an error, which
//       | already pulsed done on the offending acceptance)
module tree_sram_encoder
  import tree_pkg::*;
#(
  parameter int BASE_ADDR   = 0,
  parameter int LEVEL_DEPTH = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              bitmap_valid,
  input  logic [TREE_W-1:0] bitmap,
  input  logic              level_last,
  input  logic              tree_last,
  output logic              bitmap_ready,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [ROW_W-1:0]  sram_wdata,
  output logic              done,
  output logic              error
);

  localparam int IDX_W = $clog2(LEVEL_DEPTH);
  localparam int CNT_W = $clog2(LEVEL_DEPTH + 1);
  localparam logic [ADDR_W:0] BASE = (ADDR_W + 1)'(BASE_ADDR);

  enc_state_e        state, state_d;
  logic [CNT_W-1:0]  n, n_d, k, k_d, k_next;
  logic [8:0]        ones_acc, ones_d;
  logic [ADDR_W:0]   wr_addr, wr_addr_d, beat_addr;
  logic [7:0]        sum, sum_d;
  logic              tree_end, tree_end_d;
  logic              error_d, ready_d, we_d, done_d;
  logic [ADDR_W-1:0] addr_d;
  logic [ROW_W-1:0]  wdata_d;

  logic [TREE_W-1:0] lvl_buf [LEVEL_DEPTH];
  logic [TREE_W-1:0] row_bits;
  logic [4:0]        beat_ones, row_ones;
  logic [9:0]        ones_sum;
  logic              accept, store;
  logic              err_ones, err_depth, err_addr, err_any;

  popcount16 u_pop_beat (.bits(bitmap),   .ones(beat_ones));
  popcount16 u_pop_row  (.bits(row_bits), .ones(row_ones));

  assign row_bits  = lvl_buf[k[IDX_W-1:0]];
  assign k_next    = k + CNT_W'(1);
  assign accept    = (state == ST_FILL) && bitmap_valid && bitmap_ready;

  // Range checks use widened arithmetic so nothing wraps before comparison.
  assign ones_sum  = {1'b0, ones_acc} + 10'(beat_ones);
  assign beat_addr = wr_addr + (ADDR_W + 1)'(n);
  assign err_ones  = ones_sum > 10'(LVL_ONES_MAX);
  assign err_depth = n == CNT_W'(LEVEL_DEPTH);
  assign err_addr  = beat_addr > (ADDR_W + 1)'(ADDR_MAX);
  assign err_any   = err_ones || err_depth || err_addr;
  assign store     = accept && !err_any;

  // Next-state and next-output decode; every register holds by default.
  always_comb begin
    state_d    = state;
    n_d        = n;
    k_d        = k;
    ones_d     = ones_acc;
    wr_addr_d  = wr_addr;
    sum_d      = sum;
    tree_end_d = tree_end;
    error_d    = error;
    we_d       = 1'b0;
    addr_d     = sram_addr;
    wdata_d    = sram_wdata;
    done_d     = 1'b0;

    case (state)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_FILL;
          wr_addr_d  = BASE;
          error_d    = 1'b0;
          n_d        = '0;
          ones_d     = '0;
          tree_end_d = 1'b0;
        end
      end
      ST_FILL: begin
        if (accept) begin
          if (err_any) begin
            // The whole level is dropped; done pulses right away.
            error_d    = 1'b1;
            n_d        = '0;
            ones_d     = '0;
            tree_end_d = 1'b0;
            done_d     = 1'b1;
            state_d    = ST_DONE;
          end else begin
            n_d    = n + CNT_W'(1);
            ones_d = ones_sum[8:0];
            if (level_last || tree_last) begin
              state_d    = ST_DRAIN;
              k_d        = '0;
              sum_d      = '0;
              tree_end_d = tree_last;
            end
          end
        end
      end
      ST_DRAIN: begin
        we_d    = 1'b1;
        addr_d  = wr_addr[ADDR_W-1:0] + ADDR_W'(k);
        wdata_d = pack_row(sum, ones_acc[7:0], row_bits);
        sum_d   = sum + 8'(row_ones);
        k_d     = k_next;
        if (k_next == n) begin
          wr_addr_d = wr_addr + (ADDR_W + 1)'(n);
          n_d       = '0;
          ones_d    = '0;
          state_d   = tree_end ? ST_DONE : ST_FILL;
        end
      end
      ST_DONE: begin
        done_d  = !error;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    ready_d = (state_d == ST_FILL);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      n            <= '0;
      k            <= '0;
      ones_acc     <= '0;
      wr_addr      <= '0;
      sum          <= '0;
      tree_end     <= 1'b0;
      error        <= 1'b0;
      bitmap_ready <= 1'b0;
      sram_we      <= 1'b0;
      sram_addr    <= ADDR_W'(BASE_ADDR);
      sram_wdata   <= '0;
      done         <= 1'b0;
    end else begin
      state        <= state_d;
      n            <= n_d;
      k            <= k_d;
      ones_acc     <= ones_d;
      wr_addr      <= wr_addr_d;
      sum          <= sum_d;
      tree_end     <= tree_end_d;
      error        <= error_d;
      bitmap_ready <= ready_d;
      sram_we      <= we_d;
      sram_addr    <= addr_d;
      sram_wdata   <= wdata_d;
      done         <= done_d;
    end
  end

  // Level buffer; contents are only meaningful below n, so no reset.
  always_ff @(posedge clock) begin
    if (store) begin
      lvl_buf[n[IDX_W-1:0]] <= bitmap;
    end
  end

endmodule

// File: tb/tb_tree_sram_encoder.sv
// Directed bench for tree_sram_encoder: two instances, one at address 0 and
// one placed near the top of SRAM to hit the address limit.
module tb_tree_sram_encoder;

  logic        clock;
  logic        reset;

  logic        start, bitmap_valid, level_last, tree_last;
  logic [15:0] bitmap;
  logic        bitmap_ready, sram_we, done, error;
  logic [9:0]  sram_addr;
  logic [31:0] sram_wdata;

  logic        b_start, b_valid, b_ll, b_tl;
  logic [15:0] b_bitmap;
  logic        b_ready, b_we, b_done, b_error;
  logic [9:0]  b_addr;
  logic [31:0] b_wdata;

  int n_cmp = 0;
  int n_bad = 0;
  int hs_to = 0;
  int we_cnt = 0;
  int b_we_cnt = 0;
  logic [31:0] got [1024];

  tree_sram_encoder #(.BASE_ADDR(0), .LEVEL_DEPTH(64)) dut (
    .clock(clock), .reset(reset), .start(start),
    .bitmap_valid(bitmap_valid), .bitmap(bitmap),
    .level_last(level_last), .tree_last(tree_last),
    .bitmap_ready(bitmap_ready), .sram_we(sram_we),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .done(done), .error(error)
  );

  tree_sram_encoder #(.BASE_ADDR(1022), .LEVEL_DEPTH(64)) dut_hi (
    .clock(clock), .reset(reset), .start(b_start),
    .bitmap_valid(b_valid), .bitmap(b_bitmap),
    .level_last(b_ll), .tree_last(b_tl),
    .bitmap_ready(b_ready), .sram_we(b_we),
    .sram_addr(b_addr), .sram_wdata(b_wdata),
    .done(b_done), .error(b_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // SRAM write log, sampled mid-cycle.
  always @(negedge clock) begin
    if (sram_we === 1'b1) begin
      got[sram_addr] = sram_wdata;
      we_cnt++;
    end
    if (b_we === 1'b1) b_we_cnt++;
  end

  task automatic clear_log();
    for (int i = 0; i < 1024; i++) got[i] = 32'hDEAD_BEEF;
    we_cnt   = 0;
    b_we_cnt = 0;
  endtask

  task automatic do_start(input bit sel);
    if (sel) b_start = 1'b1; else start = 1'b1;
    @(posedge clock); #1;
    start   = 1'b0;
    b_start = 1'b0;
  endtask

  // Presents one beat and returns 1 time unit after the accepting edge.
  task automatic send_beat(input bit sel, input logic [15:0] bits,
                           input logic ll, input logic tl, output int waits);
    bit   acc;
    logic rdy;
    acc   = 1'b0;
    waits = 0;
    if (sel) begin
      b_valid = 1'b1; b_bitmap = bits; b_ll = ll; b_tl = tl;
    end else begin
      bitmap_valid = 1'b1; bitmap = bits; level_last = ll; tree_last = tl;
    end
    for (int i = 0; i < 40 && !acc; i++) begin
      @(negedge clock);
      rdy = sel ? b_ready : bitmap_ready;
      @(posedge clock); #1;
      if (rdy === 1'b1) acc = 1'b1; else waits++;
    end
    if (!acc) hs_to++;
    bitmap_valid = 1'b0; level_last = 1'b0; tree_last = 1'b0;
    b_valid = 1'b0; b_ll = 1'b0; b_tl = 1'b0;
  endtask

  task automatic wait_done(input bit sel, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clock);
      if ((sel ? b_done : done) === 1'b1) seen = 1'b1;
    end
    @(posedge clock); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    n_cmp++; if ({bitmap_ready, sram_we, done, error} !== 4'b0000) begin
      n_bad++; $display("FAIL reset_flags: got %b want 0000", {bitmap_ready, sram_we, done, error}); end
    n_cmp++; if (sram_addr !== 10'd0) begin
      n_bad++; $display("FAIL reset_addr: got %0d want 0", sram_addr); end
    n_cmp++; if (sram_wdata !== 32'd0) begin
      n_bad++; $display("FAIL reset_wdata: got %h want 0", sram_wdata); end
    n_cmp++; if (b_addr !== 10'd1022) begin
      n_bad++; $display("FAIL reset_base_addr: got %0d want 1022", b_addr); end
    reset = 1'b0;
    @(posedge clock); #1;
    n_cmp++; if (bitmap_ready !== 1'b0) begin
      n_bad++; $display("FAIL idle_ready: got %b want 0", bitmap_ready); end
    do_start(0);
    n_cmp++; if (bitmap_ready !== 1'b1) begin
      n_bad++; $display("FAIL start_ready: got %b want 1", bitmap_ready); end
  endtask

  task automatic test_basic();
    int w;
    clear_log();
    hs_to = 0;
    do_start(0);
    send_beat(0, 16'h8001, 1'b0, 1'b0, w);
    send_beat(0, 16'hFFFF, 1'b0, 1'b1, w);
    n_cmp++; if (sram_we !== 1'b0) begin
      n_bad++; $display("FAIL basic_we_e0: got %b want 0", sram_we); end
    @(posedge clock); #1;
    n_cmp++; if ({sram_we, sram_addr, sram_wdata} !== {1'b1, 10'd0, 32'h0012_8001}) begin
      n_bad++; $display("FAIL basic_row0: got we=%b addr=%0d data=%h want 1/0/00128001", sram_we, sram_addr, sram_wdata); end
    @(posedge clock); #1;
    n_cmp++; if ({sram_we, sram_addr, sram_wdata} !== {1'b1, 10'd1, 32'h0212_FFFF}) begin
      n_bad++; $display("FAIL basic_row1: got we=%b addr=%0d data=%h want 1/1/0212ffff", sram_we, sram_addr, sram_wdata); end
    @(posedge clock); #1;
    n_cmp++; if ({done, sram_we} !== 2'b10) begin
      n_bad++; $display("FAIL basic_done: got done,we=%b want 10", {done, sram_we}); end
    @(posedge clock); #1;
    n_cmp++; if ({done, error, bitmap_ready} !== 3'b000) begin
      n_bad++; $display("FAIL basic_after: got done,err,rdy=%b want 000", {done, error, bitmap_ready}); end
    n_cmp++; if (we_cnt !== 2) begin
      n_bad++; $display("FAIL basic_we_count: got %0d want 2", we_cnt); end
    n_cmp++; if (hs_to !== 0) begin
      n_bad++; $display("FAIL basic_handshake: got %0d timeouts want 0", hs_to); end
  endtask

  task automatic test_multi_level();
    int w;
    bit seen;
    clear_log();
    hs_to = 0;
    do_start(0);
    send_beat(0, 16'hC000, 1'b1, 1'b0, w);
    n_cmp++; if (bitmap_ready !== 1'b0) begin
      n_bad++; $display("FAIL ml_ready_drain: got %b want 0", bitmap_ready); end
    @(posedge clock); #1;
    n_cmp++; if ({sram_we, bitmap_ready, sram_addr, sram_wdata} !== {2'b11, 10'd0, 32'h0002_C000}) begin
      n_bad++; $display("FAIL ml_overlap: got we=%b rdy=%b addr=%0d data=%h want 1/1/0/0002c000", sram_we, bitmap_ready, sram_addr, sram_wdata); end
    send_beat(0, 16'h0001, 1'b0, 1'b0, w);
    send_beat(0, 16'h0003, 1'b0, 1'b1, w);
    wait_done(0, seen);
    n_cmp++; if (seen !== 1'b1) begin
      n_bad++; $display("FAIL ml_done: got %b want 1", seen); end
    n_cmp++; if (got[1] !== 32'h0003_0001) begin
      n_bad++; $display("FAIL ml_row1: got %h want 00030001", got[1]); end
    n_cmp++; if (got[2] !== 32'h0103_0003) begin
      n_bad++; $display("FAIL ml_row2: got %h want 01030003", got[2]); end
    n_cmp++; if ({we_cnt, error} !== {32'd3, 1'b0}) begin
      n_bad++; $display("FAIL ml_count_err: got %0d/%b want 3/0", we_cnt, error); end
    n_cmp++; if (hs_to !== 0) begin
      n_bad++; $display("FAIL ml_handshake: got %0d timeouts want 0", hs_to); end
  endtask

  task automatic test_zero_level();
    int w;
    bit seen;
    clear_log();
    hs_to = 0;
    do_start(0);
    send_beat(0, 16'h0000, 1'b1, 1'b1, w);
    wait_done(0, seen);
    n_cmp++; if ({seen, got[0]} !== {1'b1, 32'h0000_0000}) begin
      n_bad++; $display("FAIL zero_row: got done=%b data=%h want 1/00000000", seen, got[0]); end
    n_cmp++; if (we_cnt !== 1) begin
      n_bad++; $display("FAIL zero_we_count: got %0d want 1", we_cnt); end
  endtask

  task automatic test_ones_overflow();
    int w;
    bit seen;
    clear_log();
    hs_to = 0;
    do_start(0);
    for (int i = 0; i < 15; i++) send_beat(0, 16'hFFFF, 1'b0, 1'b0, w);
    send_beat(0, 16'hFFFF, 1'b0, 1'b0, w);
    n_cmp++; if ({done, error, bitmap_ready} !== 3'b110) begin
      n_bad++; $display("FAIL ovf_flags: got done,err,rdy=%b want 110", {done, error, bitmap_ready}); end
    @(posedge clock); #1;
    n_cmp++; if (done !== 1'b0) begin
      n_bad++; $display("FAIL ovf_done_width: got %b want 0", done); end
    repeat (3) @(posedge clock);
    #1;
    n_cmp++; if ({we_cnt, error} !== {32'd0, 1'b1}) begin
      n_bad++; $display("FAIL ovf_no_write: got writes=%0d err=%b want 0/1", we_cnt, error); end
    do_start(0);
    n_cmp++; if ({error, bitmap_ready} !== 2'b01) begin
      n_bad++; $display("FAIL ovf_start_clear: got err,rdy=%b want 01", {error, bitmap_ready}); end
    send_beat(0, 16'h0101, 1'b0, 1'b1, w);
    wait_done(0, seen);
    n_cmp++; if (got[0] !== 32'h0002_0101) begin
      n_bad++; $display("FAIL ovf_recover: got %h want 00020101", got[0]); end
    n_cmp++; if (hs_to !== 0) begin
      n_bad++; $display("FAIL ovf_handshake: got %0d timeouts want 0", hs_to); end
  endtask

  task automatic test_back_to_back();
    int w;
    bit seen;
    clear_log();
    hs_to = 0;
    do_start(0);
    send_beat(0, 16'h1234, 1'b0, 1'b0, w);
    send_beat(0, 16'h00F0, 1'b1, 1'b0, w);
    send_beat(0, 16'h0F0F, 1'b0, 1'b1, w);
    n_cmp++; if (w !== 2) begin
      n_bad++; $display("FAIL b2b_holdoff: got %0d stalled cycles want 2", w); end
    wait_done(0, seen);
    n_cmp++; if (got[0] !== 32'h0009_1234) begin
      n_bad++; $display("FAIL b2b_row0: got %h want 00091234", got[0]); end
    n_cmp++; if (got[1] !== 32'h0509_00F0) begin
      n_bad++; $display("FAIL b2b_row1: got %h want 050900f0", got[1]); end
    n_cmp++; if (got[2] !== 32'h0008_0F0F) begin
      n_bad++; $display("FAIL b2b_row2: got %h want 00080f0f", got[2]); end
    n_cmp++; if ({seen, we_cnt} !== {1'b1, 32'd3}) begin
      n_bad++; $display("FAIL b2b_done_count: got %b/%0d want 1/3", seen, we_cnt); end
    n_cmp++; if (hs_to !== 0) begin
      n_bad++; $display("FAIL b2b_handshake: got %0d timeouts want 0", hs_to); end
  endtask

  task automatic test_addr_overflow();
    int w;
    clear_log();
    hs_to = 0;
    do_start(1);
    send_beat(1, 16'h0001, 1'b0, 1'b0, w);
    do_start(1);
    send_beat(1, 16'h0002, 1'b0, 1'b0, w);
    send_beat(1, 16'h0004, 1'b1, 1'b0, w);
    n_cmp++; if ({b_done, b_error} !== 2'b11) begin
      n_bad++; $display("FAIL addr_ovf_flags: got done,err=%b want 11", {b_done, b_error}); end
    repeat (3) @(posedge clock);
    #1;
    n_cmp++; if ({b_we_cnt, b_addr} !== {32'd0, 10'd1022}) begin
      n_bad++; $display("FAIL addr_ovf_no_write: got writes=%0d addr=%0d want 0/1022", b_we_cnt, b_addr); end
    n_cmp++; if (hs_to !== 0) begin
      n_bad++; $display("FAIL addr_ovf_handshake: got %0d timeouts want 0", hs_to); end
  endtask

  task automatic test_reset_mid_drain();
    int w;
    bit seen;
    clear_log();
    hs_to = 0;
    do_start(0);
    send_beat(0, 16'h0001, 1'b0, 1'b0, w);
    send_beat(0, 16'h0002, 1'b0, 1'b0, w);
    send_beat(0, 16'h0004, 1'b0, 1'b1, w);
    @(posedge clock); #6;
    reset = 1'b1;
    #1;
    n_cmp++; if ({bitmap_ready, sram_we, done, error, sram_addr, sram_wdata} !== {4'b0000, 10'd0, 32'd0}) begin
      n_bad++; $display("FAIL rst_async: got rdy=%b we=%b done=%b err=%b addr=%0d data=%h want all 0",
                        bitmap_ready, sram_we, done, error, sram_addr, sram_wdata); end
    n_cmp++; if ({we_cnt, got[0]} !== {32'd1, 32'h0003_0001}) begin
      n_bad++; $display("FAIL rst_partial: got writes=%0d row0=%h want 1/00030001", we_cnt, got[0]); end
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;
    clear_log();
    do_start(0);
    send_beat(0, 16'h0101, 1'b1, 1'b1, w);
    wait_done(0, seen);
    n_cmp++; if ({seen, we_cnt, got[0]} !== {1'b1, 32'd1, 32'h0002_0101}) begin
      n_bad++; $display("FAIL rst_restart: got done=%b writes=%0d row0=%h want 1/1/00020101", seen, we_cnt, got[0]); end
    n_cmp++; if (hs_to !== 0) begin
      n_bad++; $display("FAIL rst_handshake: got %0d timeouts want 0", hs_to); end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0; bitmap_valid = 1'b0; bitmap = 16'h0; level_last = 1'b0; tree_last = 1'b0;
    b_start = 1'b0; b_valid = 1'b0; b_bitmap = 16'h0; b_ll = 1'b0; b_tl = 1'b0;
    test_reset();
    test_basic();
    test_multi_level();
    test_zero_level();
    test_ones_overflow();
    test_back_to_back();
    test_addr_overflow();
    test_reset_mid_drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
